data_ram_resp: RTL
==================

Name: data_ram_resp

Overview:
- Memory-side responder for the core's shared data-RAM port, the bus that load and store requests are steered onto.
- Word-organised synchronous RAM with sub-word load/store, a configurable read latency, a ready/valid completion handshake and an error pulse for illegal requests.
- Sits between the RAM port arbitration and the backing storage array, inside the SoC RAM subsystem.

Parameters:
- DEPTH, 256, number of 32-bit words; the array is indexed by iRAM_ADDR modulo DEPTH.
- RD_LAT, 1, read latency in cycles from request acceptance to oRAM_VALID; legal values are 1 to 4.

Ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST_N  in  1  reset, asynchronous, active-low.
- iRAM_CE  in  1  chip enable; the request is ignored when low.
- iRAM_RD  in  1  read request.
- iRAM_WR  in  1  write request.
- iRAM_ADDR  in  8  word address.
- iRAM_BOFF  in  2  byte offset within the word.
- iRAM_FUNCT3  in  3  access size and sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; for stores 000 sb, 001 sh, 010 sw.
- iRAM_DATA_WR  in  32  store data, right-aligned in bits [7:0], [15:0] or [31:0].
- oRAM_DATA_RD  out  32  load data, extended to 32 bits and right-aligned.
- oRAM_READY  out  1  a request is accepted this cycle when high.
- oRAM_VALID  out  1  one-cycle pulse: read data valid, or write complete.
- oRAM_ERR  out  1  one-cycle pulse together with oRAM_VALID on a rejected request.

Behaviour:
- Reset: asynchronous assertion of iRST_N sets FSM=IDLE, oRAM_READY=1, oRAM_VALID=0, oRAM_ERR=0, oRAM_DATA_RD=0 and the latency counter to 0.
  - Array contents are not reset.
  - Reset mid-read drops the pending read with no VALID pulse.
  - Writes committed on earlier edges persist.
- Accept: a request is accepted when iRAM_CE & (iRAM_RD | iRAM_WR) & oRAM_READY at a rising edge.
- Illegal requests (accepted, no array access, oRAM_DATA_RD=0, VALID=1 and ERR=1 on the next cycle):
  - iRAM_RD and iRAM_WR both high.
  - Misalignment: half access with iRAM_BOFF[0]=1, or word access with iRAM_BOFF!=0.
  - Undefined funct3: 011, 110, 111, or a store with funct3 100 or 101.
- FSM states:
  - IDLE: READY=1.
    - Legal write: bytes commit at the accepting edge; stay IDLE; VALID=1 next cycle. Back-to-back writes are allowed at one per cycle.
    - Legal read: go to RD_WAIT, load the counter with RD_LAT-1, set READY=0.
    - Illegal request: go to ERR_RSP, set READY=0.
  - RD_WAIT: READY=0. The counter decrements each cycle. At counter==0, drive oRAM_DATA_RD, pulse VALID, and return to IDLE with READY=1.
    - Net effect: VALID asserts RD_LAT cycles after the accepting edge.
    - With RD_LAT=1, RD_WAIT lasts one cycle.
  - ERR_RSP: pulse VALID and ERR for one cycle, then go to IDLE.
- Read path:
  - The word is sampled from the array at the accepting edge; the address, offset and funct3 are captured.
  - Byte is selected by BOFF; half by BOFF[1].
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Write path: byte enables are derived from funct3 and BOFF.
  - sb writes DATA_WR[7:0] to byte lane BOFF.
  - sh writes DATA_WR[15:0] to lanes {BOFF[1],0} and {BOFF[1],1}.
  - sw writes all lanes.
  - Unselected lanes are unchanged.
- Read-after-write: a read accepted on the cycle after a write to the same word returns the new data.
  - No same-edge collision exists: a write and a read cannot be accepted on the same edge.
- oRAM_DATA_RD holds its last value between VALID pulses. It is set to 0 only by reset or an error response.
- Address wrap: iRAM_ADDR >= DEPTH wraps modulo DEPTH, with no error.
- Requests presented while READY=0 are ignored; the initiator holds them until accepted.

Test Plan:
- Word store then load: sw addr=0x10 data=0xDEADBEEF, then lw addr=0x10 with RD_LAT=1 -> VALID one cycle after read acceptance, DATA_RD=0xDEADBEEF, ERR=0.
- Sub-word sign handling: word 0x80FF7F01 at 0x20 -> lb boff=3 gives 0xFFFFFF80; lbu boff=3 gives 0x00000080; lh boff=2 gives 0xFFFF80FF; lhu boff=0 gives 0x00007F01.
- Byte-lane store: init 0x11223344 at 0x05; sb boff=1 data=0xAA -> word 0x1122AA44; sh boff=2 data=0xBEEF -> word 0xBEEFAA44.
- Errors: lw boff=2 -> VALID=1, ERR=1, DATA_RD=0, array unchanged; RD=WR=1 -> same response; sh boff=1 -> no lane written.
- Latency and stall: RD_LAT=3, lw at cycle 0 -> READY low in cycles 1-3, VALID at cycle 3; a request presented in cycle 2 is not accepted until READY returns high.
- Reset mid-read: assert iRST_N=0 during RD_WAIT -> VALID never pulses, READY=1, DATA_RD=0; a previously written word still reads back correctly after reset.

Source files
------------

// File: rtl/data_ram_resp.sv
// data_ram_resp: memory-side responder for the shared data-RAM port.
// Word-organised RAM with sub-word load/store, RD_LAT read latency, ready/valid completion and error pulses.
module data_ram_resp #(
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iRAM_CE,
    input  logic        iRAM_RD,
    input  logic        iRAM_WR,
    input  logic [7:0]  iRAM_ADDR,
    input  logic [1:0]  iRAM_BOFF,
    input  logic [2:0]  iRAM_FUNCT3,
    input  logic [31:0] iRAM_DATA_WR,
    output logic [31:0] oRAM_DATA_RD,
    output logic        oRAM_READY,
    output logic        oRAM_VALID,
    output logic        oRAM_ERR
);

    localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        ERR_RSP
    } state_e;

    state_e        state_q;
    logic [1:0]    rdCnt_q;
    logic [31:0]   rdPend_q;
    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] wordIdx;
    logic [31:0]   rdWord;
    logic [7:0]    byteSel;
    logic [15:0]   halfSel;
    logic [31:0]   loadData;
    logic [31:0]   wrLanes;
    logic [3:0]    byteEn;
    logic          misaligned;
    logic          f3Defined;
    logic          reqIllegal;
    logic          reqAccept;
    logic          memWrEn;

    assign wordIdx   = AW'(32'(iRAM_ADDR) % 32'(DEPTH));
    assign rdWord    = mem_q[wordIdx];
    assign reqAccept = iRAM_CE & (iRAM_RD | iRAM_WR) & oRAM_READY;
    assign memWrEn   = reqAccept & iRAM_WR & ~reqIllegal & iRST_N;

    // Request legality: conflicting direction, undefined size/sign code, or misaligned offset.
    always_comb begin
        misaligned = 1'b0;
        case (iRAM_FUNCT3[1:0])
            2'b01:   misaligned = iRAM_BOFF[0];
            2'b10:   misaligned = (iRAM_BOFF != 2'b00);
            default: misaligned = 1'b0;
        endcase

        f3Defined = 1'b0;
        if (iRAM_WR) begin
            f3Defined = (iRAM_FUNCT3 == 3'b000) || (iRAM_FUNCT3 == 3'b001) ||
                        (iRAM_FUNCT3 == 3'b010);
        end else begin
            f3Defined = (iRAM_FUNCT3 == 3'b000) || (iRAM_FUNCT3 == 3'b001) ||
                        (iRAM_FUNCT3 == 3'b010) || (iRAM_FUNCT3 == 3'b100) ||
                        (iRAM_FUNCT3 == 3'b101);
        end

        reqIllegal = (iRAM_RD & iRAM_WR) | misaligned | ~f3Defined;
    end

    always_comb begin
        byteEn  = 4'b0000;
        wrLanes = iRAM_DATA_WR;
        case (iRAM_FUNCT3[1:0])
            2'b00: begin
                byteEn[iRAM_BOFF] = 1'b1;
                wrLanes           = {4{iRAM_DATA_WR[7:0]}};
            end
            2'b01: begin
                byteEn  = iRAM_BOFF[1] ? 4'b1100 : 4'b0011;
                wrLanes = {2{iRAM_DATA_WR[15:0]}};
            end
            2'b10: begin
                byteEn  = 4'b1111;
                wrLanes = iRAM_DATA_WR;
            end
            default: begin
                byteEn  = 4'b0000;
                wrLanes = iRAM_DATA_WR;
            end
        endcase
    end

    // Load alignment and extension happen at acceptance so the response only has to be delayed.
    always_comb begin
        byteSel = rdWord[{iRAM_BOFF, 3'b000} +: 8];
        halfSel = iRAM_BOFF[1] ? rdWord[31:16] : rdWord[15:0];
        case (iRAM_FUNCT3)
            3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b010:  loadData = rdWord;
            3'b100:  loadData = {24'd0, byteSel};
            3'b101:  loadData = {16'd0, halfSel};
            default: loadData = 32'd0;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (memWrEn) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem_q[wordIdx][8*b +: 8] <= wrLanes[8*b +: 8];
                end
            end
        end
    end

    // VALID is raised on the edge entering the cycle whose counter reads zero, so it lands RD_LAT cycles after acceptance.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= IDLE;
            rdCnt_q      <= 2'd0;
            rdPend_q     <= 32'd0;
            oRAM_READY   <= 1'b1;
            oRAM_VALID   <= 1'b0;
            oRAM_ERR     <= 1'b0;
            oRAM_DATA_RD <= 32'd0;
        end else begin
            oRAM_VALID <= 1'b0;
            oRAM_ERR   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (reqAccept) begin
                        if (reqIllegal) begin
                            state_q      <= ERR_RSP;
                            oRAM_READY   <= 1'b0;
                            oRAM_VALID   <= 1'b1;
                            oRAM_ERR     <= 1'b1;
                            oRAM_DATA_RD <= 32'd0;
                        end else if (iRAM_WR) begin
                            oRAM_VALID <= 1'b1;
                        end else begin
                            state_q    <= RD_WAIT;
                            oRAM_READY <= 1'b0;
                            rdCnt_q    <= LAT_M1;
                            rdPend_q   <= loadData;
                            if (LAT_M1 == 2'd0) begin
                                oRAM_VALID   <= 1'b1;
                                oRAM_DATA_RD <= loadData;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (rdCnt_q == 2'd0) begin
                        state_q    <= IDLE;
                        oRAM_READY <= 1'b1;
                    end else begin
                        rdCnt_q <= rdCnt_q - 2'd1;
                        if (rdCnt_q == 2'd1) begin
                            oRAM_VALID   <= 1'b1;
                            oRAM_DATA_RD <= rdPend_q;
                        end
                    end
                end
                ERR_RSP: begin
                    state_q    <= IDLE;
                    oRAM_READY <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    oRAM_READY <= 1'b1;
                end
            endcase
        end
    end

endmodule
